uart_stream_bridge: RTL

Bridges the team's valid/ready byte streams to the CPU-style strobe port of the CoreUART instance (CSN/WEN/OEN/DATA_IN/DATA_OUT/TXRDY/RXRDY). On the transmit side it writes stream bytes into the UART when the UART can accept them. On the receive side it reads received bytes out of the UART into a 2-entry output buffer, with the error flags attached to each byte. It sits directly upstream and downstream of the UART core, with the core configured for RX_FIFO=0 and either TX_FIFO setting.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_stream_bridge_rxbuf.sv | 57 +++++
 rtl/uart_stream_bridge.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for uart_stream_bridge: FSM states, RX buffer entry,
// guard/counter sizing and a saturating-increment helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    GUARD = 2'd3
  } state_t;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  localparam int GUARD_MIN = 2;
  localparam int ERRCNT_W  = 8;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] value,
                                                   input logic                inc);
    sat_inc = (inc && (value != {ERRCNT_W{1'b1}})) ? value + 1'b1 : value;
  endfunction

endpackage

// File: rtl/uart_stream_bridge_rxbuf.sv
// Two-entry receive buffer of {perr, ferr, data}; head entry is always presented
// on the output, push and pop may coincide.
module uart_stream_bridge_rxbuf
  import uart_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET_N,
  input  logic      push,
  input  rx_entry_t push_entry,
  input  logic      pop,
  output rx_entry_t head,
  output logic [1:0] count
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic [1:0] count_next;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      rx_entry_t entry_reg;
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= push_entry;
        end
      end
    end
  endgenerate

  assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign count = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Valid/ready byte streams to CoreUART strobe port bridge with round-robin TX/RX
// arbitration. Error counters are built only with UART_STREAM_BRIDGE_ERRCNT_EN.
module uart_stream_bridge
  import uart_pkg::*;
#(
  parameter int GUARD_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       uart_csn,
  output logic       uart_wen,
  output logic       uart_oen,
  output logic [7:0] uart_din,
  input  logic [7:0] uart_dout,
  input  logic       uart_txrdy,
  input  logic       uart_rxrdy,
  input  logic       uart_parity_err,
  input  logic       uart_framing_err,
  input  logic       uart_overflow,
  input  logic       err_clr,
  output logic [7:0] cnt_perr,
  output logic [7:0] cnt_ferr,
  output logic [7:0] cnt_ovf
);

  localparam int         GUARD_EFF  = (GUARD_CYCLES < GUARD_MIN) ? GUARD_MIN : GUARD_CYCLES;
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_EFF - 1);

  state_t     state_reg, state_next;
  logic [3:0] guard_cnt_reg, guard_cnt_next;
  logic       prio_rx_reg, prio_rx_next;
  logic       csn_reg, wen_reg, oen_reg;
  logic [7:0] din_reg;

  logic       rx_req, tx_win, tx_hs, rx_grant;
  logic       push, pop;
  rx_entry_t  push_entry, head;
  logic [1:0] count;

  // TX loses the slot only when RX is requesting and holds the round-robin priority.
  assign rx_req   = uart_rxrdy && (count < 2'd2);
  assign tx_win   = !(rx_req && prio_rx_reg);
  assign tx_ready = (state_reg == IDLE) && uart_txrdy && tx_win;
  assign tx_hs    = tx_ready && tx_valid;
  assign rx_grant = (state_reg == IDLE) && rx_req && !tx_hs;

  always_comb begin
    state_next     = state_reg;
    guard_cnt_next = guard_cnt_reg;
    prio_rx_next   = prio_rx_reg;
    case (state_reg)
      IDLE: begin
        if (tx_hs) begin
          state_next   = WR;
          prio_rx_next = 1'b1;
        end else if (rx_grant) begin
          state_next   = RD;
          prio_rx_next = 1'b0;
        end
      end
      WR, RD: begin
        state_next     = GUARD;
        guard_cnt_next = 4'd0;
      end
      GUARD: begin
        if (guard_cnt_reg == GUARD_LAST) state_next = IDLE;
        else guard_cnt_next = guard_cnt_reg + 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change only on clock edges.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      guard_cnt_reg <= 4'd0;
      prio_rx_reg   <= 1'b1;
      csn_reg       <= 1'b1;
      wen_reg       <= 1'b1;
      oen_reg       <= 1'b1;
      din_reg       <= 8'd0;
    end else begin
      state_reg     <= state_next;
      guard_cnt_reg <= guard_cnt_next;
      prio_rx_reg   <= prio_rx_next;
      csn_reg       <= !((state_next == WR) || (state_next == RD));
      wen_reg       <= (state_next != WR);
      oen_reg       <= (state_next != RD);
      if (tx_hs) din_reg <= tx_data;
    end
  end

  assign uart_csn = csn_reg;
  assign uart_wen = wen_reg;
  assign uart_oen = oen_reg;
  assign uart_din = din_reg;

  assign push       = (state_reg == RD);
  assign push_entry = '{perr: uart_parity_err, ferr: uart_framing_err, data: uart_dout};
  assign pop        = rx_valid && rx_ready;

  uart_stream_bridge_rxbuf u_rxbuf (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign rx_valid = (count != 2'd0);
  assign rx_data  = head.data;
  assign rx_perr  = head.perr;
  assign rx_ferr  = head.ferr;

`ifdef UART_STREAM_BRIDGE_ERRCNT_EN
  logic       ovf_d_reg;
  logic [2:0] cnt_inc;

  assign cnt_inc = {uart_overflow && !ovf_d_reg, push && push_entry.ferr, push && push_entry.perr};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ovf_d_reg <= 1'b0;
    else          ovf_d_reg <= uart_overflow;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [ERRCNT_W-1:0] cnt_reg;
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)     cnt_reg <= '0;
        else if (err_clr) cnt_reg <= '0;
        else              cnt_reg <= sat_inc(cnt_reg, cnt_inc[gi]);
      end
    end
  endgenerate

  assign cnt_perr = g_cnt[0].cnt_reg;
  assign cnt_ferr = g_cnt[1].cnt_reg;
  assign cnt_ovf  = g_cnt[2].cnt_reg;
`else
  logic unused_errcnt_inputs;
  assign unused_errcnt_inputs = err_clr ^ uart_overflow;
  assign cnt_perr = 8'd0;
  assign cnt_ferr = 8'd0;
  assign cnt_ovf  = 8'd0;
`endif

endmodule
